pio_key_in: RTL and testbench



---
 rtl/pio_key_in.sv | 109 ++++++++++
 tb/tb_pio_key_in.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pio_key_in.sv
// Avalon-MM input PIO for keys/switches: two-flop synchronizer, per-bit debounce,
// per-bit edge capture with write-1-to-clear, and a maskable level interrupt.
module pio_key_in #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 0,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] state_prev_q, state_prev_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;

  function automatic logic [WIDTH-1:0] edge_sel(input logic [WIDTH-1:0] prev,
                                                input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rise;
    fall = prev & ~cur;
    rise = ~prev & cur;
    case (EDGE_TYPE)
      0:       edge_sel = fall;
      1:       edge_sel = rise;
      default: edge_sel = fall | rise;
    endcase
  endfunction

  always_comb begin
    sync1_d      = in_port;
    sync2_d      = sync1_q;
    state_d      = state_q;
    state_prev_d = state_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching clocks.
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_LAST) begin
        state_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end

    edge_set = edge_sel(state_prev_q, state_q);
    wr_en    = chipselect && !write_n;
    mask_d   = (wr_en && address == 2'd2) ? writedata : mask_q;
    w1c      = (wr_en && address == 2'd3) ? writedata : '0;
    // Set is ORed in after the clear so a coincident edge survives the W1C.
    edge_d   = (edge_q & ~w1c) | edge_set;

    case (address)
      2'd0:    readdata_d = state_q;
      2'd2:    readdata_d = mask_q;
      2'd3:    readdata_d = edge_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= IDLE_VEC;
      sync2_q      <= IDLE_VEC;
      state_q      <= IDLE_VEC;
      state_prev_q <= IDLE_VEC;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      edge_q       <= '0;
      mask_q       <= '0;
      readdata_q   <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      state_prev_q <= state_prev_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      edge_q       <= edge_d;
      mask_q       <= mask_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_key_in.sv
// Bench for pio_key_in with DEBOUNCE_CYCLES=4, WIDTH=4, falling-edge capture, idle-high keys.
module tb_pio_key_in;
  localparam int W  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [W-1:0] writedata = '0;
  logic [W-1:0] in_port = 4'hF;
  logic [W-1:0] readdata;
  logic         irq;

  pio_key_in #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   addr;
    logic [W-1:0] exp_rd;
    logic         exp_irq;
    string        name;
  } vec_t;

  vec_t         vecs [14];
  logic [W-1:0] exp_q [$];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [W-1:0] exp, input string nm);
    address = a; chipselect = 1'b0; write_n = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    chk(nm, readdata, exp_q.pop_front());
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rd(vecs[i].addr, vecs[i].exp_rd, vecs[i].name);
      chk({vecs[i].name, "_irq"}, irq, vecs[i].exp_irq);
    end
  endtask

  initial begin
    vecs[0]  = '{2'd0, 4'hF, 1'b0, "rst_data"};
    vecs[1]  = '{2'd3, 4'h0, 1'b0, "rst_edge"};
    vecs[2]  = '{2'd1, 4'h0, 1'b0, "rst_rsvd"};
    vecs[3]  = '{2'd0, 4'hF, 1'b0, "glitch_data"};
    vecs[4]  = '{2'd3, 4'h0, 1'b0, "glitch_edge"};
    vecs[5]  = '{2'd0, 4'hF, 1'b0, "ro_data"};
    vecs[6]  = '{2'd1, 4'h0, 1'b0, "ro_rsvd"};
    vecs[7]  = '{2'd3, 4'h4, 1'b0, "fall2_edge"};
    vecs[8]  = '{2'd0, 4'hB, 1'b0, "fall2_data"};
    vecs[9]  = '{2'd3, 4'h0, 1'b0, "rise2_edge"};
    vecs[10] = '{2'd0, 4'hF, 1'b0, "rise2_data"};
    vecs[11] = '{2'd0, 4'hF, 1'b0, "rst2_data"};
    vecs[12] = '{2'd3, 4'h0, 1'b0, "rst2_edge"};
    vecs[13] = '{2'd2, 4'h0, 1'b0, "rst2_mask"};

    // Reset state
    tick(3);
    chk("rst_readdata", readdata, 4'h0);
    chk("rst_irq", irq, 1'b0);
    reset_n = 1'b1;
    tick(1);
    run_vecs(0, 2);

    // Glitch of DC-1 clocks on bit 0 must be rejected
    in_port = 4'hE;
    tick(DC - 1);
    in_port = 4'hF;
    tick(8);
    run_vecs(3, 4);

    // Writes to data and reserved registers are ignored
    wr(2'd0, 4'h0);
    wr(2'd1, 4'hF);
    run_vecs(5, 6);

    // Bit 2 falls: state updates 2 sync + DC debounce clocks later, readdata one after
    address = 2'd0;
    in_port = 4'hB;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) chk("deb_not_yet", readdata, 4'hF);
      if (k == 7) chk("deb_accept", readdata, 4'hB);
    end
    tick(2);
    run_vecs(7, 8);

    // Unmask then W1C
    wr(2'd2, 4'h4);
    chk("irq_unmask", irq, 1'b1);
    wr(2'd3, 4'h4);
    chk("irq_w1c", irq, 1'b0);
    rd(2'd3, 4'h0, "w1c_edge");

    // Rising edge is not captured
    in_port = 4'hF;
    tick(10);
    run_vecs(9, 10);

    // Falling edge on bit 1 coincides with a W1C of bit 1: set wins
    wr(2'd2, 4'h2);
    in_port = 4'hD;
    tick(2 + DC);
    wr(2'd3, 4'h2);
    chk("set_wins_irq", irq, 1'b1);
    rd(2'd3, 4'h2, "set_wins_edge");
    wr(2'd2, 4'h0);
    chk("mask_off_irq", irq, 1'b0);
    rd(2'd3, 4'h2, "mask_off_edge");
    wr(2'd2, 4'h2);
    chk("mask_on_irq", irq, 1'b1);

    // Reset mid-debounce on bit 3 with bit 1 pending
    in_port = 4'h5;
    tick(4);
    chk("pre_rst_irq", irq, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_irq", irq, 1'b0);
    chk("rst_async_rd", readdata, 4'h0);
    in_port = 4'h0;
    tick(2);
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    run_vecs(11, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
